ddr3_write_arbiter: RTL and testbench
=====================================

Name: ddr3_write_arbiter

Overview:
Two-requester AXI4 write-channel arbiter in the DDR3 clock domain (axi_clock, 122.76 MHz).
It shares the single DDR3 controller write port between the raw-data acquisition unit (port 0) and the USB bulk-out bridge (port 1).
Arbitration is burst-locked: a grant is held from AW acceptance until the B response completes, with one outstanding transaction at a time.
It also reports grant, busy and burst-length-error status for the top-level control logic.

Parameters:
ID_WIDTH, 4, AXI ID width (ISB = ID_WIDTH-1).
AXI_WIDTH, 32, write-data width (MSB = AXI_WIDTH-1).
AXI_ADDRS, 27, byte-address width (ASB = AXI_ADDRS-1).
AXI_KEEPS, AXI_WIDTH/8, strobe width (SSB = AXI_KEEPS-1).
FIXED_PRIO, 0, 1 = port 0 always wins; 0 = round-robin.

Ports:
clock  in  1  AXI/DDR3 clock; all logic is on the rising edge.
arst_n  in  1  asynchronous active-low reset.
sN_awvalid/sN_awready  in/out  1  AW handshake, N = 0,1.
sN_awaddr  in  AXI_ADDRS  burst start byte address.
sN_awid  in  ID_WIDTH  transaction ID.
sN_awlen  in  8  beats minus 1.
sN_awburst  in  2  burst type.
sN_wvalid/sN_wready  in/out  1  W handshake.
sN_wlast  in  1  final beat of the burst.
sN_wstrb  in  AXI_KEEPS  byte strobes.
sN_wdata  in  AXI_WIDTH  write data.
sN_bvalid/sN_bready  out/in  1  B handshake.
sN_bresp  out  2  write response.
sN_bid  out  ID_WIDTH  response ID.
m_aw*, m_w*, m_b*  (mirrored)  same widths  controller-side AXI4 write channels, directions reversed.
grant_o  out  2  one-hot current grant; 00 when idle.
busy_o  out  1  a transaction is in progress.
len_err_o  out  1  sticky burst-length mismatch flag.

Behaviour:
- Reset (async, arst_n=0):
  - state=IDLE, grant=00, last_grant=port 1 (so port 0 wins the first tie).
  - beat counter=0, len_err_o=0.
  - All outgoing valid/ready = 0; m_aw*/m_w* data fields = 0.
- IDLE:
  - Sample s0_awvalid and s1_awvalid.
  - None valid: stay in IDLE.
  - One valid: grant that port.
  - Both valid: FIXED_PRIO=1 grants port 0; otherwise grant the port that is not last_grant.
  - Register the grant and move to ADDR. m_awvalid rises on the cycle after the request is seen (1-cycle arbitration latency).
- ADDR:
  - m_aw{addr,id,len,burst} = registered copy of the granted port's fields; m_awvalid=1.
  - Granted sN_awready = m_awready.
  - On the handshake: load beat counter = awlen, go to DATA.
  - m_awvalid holds until accepted (AXI stable rule).
- DATA:
  - m_w{valid,last,strb,data} is a combinational mux of the granted port; granted sN_wready = m_wready.
  - Each W handshake decrements the beat counter.
  - A handshake with wlast=1 moves to RESP.
  - If wlast=1 with counter≠0, or counter==0 without wlast, set len_err_o=1 (sticky until reset). The transition still follows wlast.
- RESP:
  - Granted sN_bvalid = m_bvalid; m_bready = granted sN_bready; bresp and bid pass through.
  - On the handshake: last_grant=grant, grant=00, go to IDLE.
- Non-granted port: awready=wready=bvalid=0 at all times. W beats presented before its AW is granted are stalled, not dropped.
- Ordering: W beats are never forwarded before the AW handshake. Minimum turnaround is one IDLE cycle between bursts.
- busy_o = (state≠IDLE). grant_o is registered.
- Reset mid-burst: return to IDLE immediately and abandon the in-flight burst. Upstream blocks share the same reset (axi_reset), so they abandon it too.
- No timeout: a stalled requester holds the port indefinitely. This is intentional; acquisition always completes its bursts.
- awburst is passed through unchecked. awaddr is not modified (no address offsetting).

Decomposition:
- Shared package tart_axi_pkg:
  - burst encodings BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10;
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - arbiter state enum {IDLE, ADDR, DATA, RESP}.
- One natural sub-module, rr_arbiter2: combinational 2-way grant select from (req[1:0], last_grant, FIXED_PRIO) producing a one-hot grant. It is reusable for the planned read-port arbiter.

Test Plan:
- Only s0 requests, awaddr=0x0001000, awlen=3, four beats 0xA0..0xA3:
  - m_awvalid rises 1 cycle after s0_awvalid; four m_w beats arrive in order, wlast on beat 4;
  - s0 receives bresp=OKAY; grant_o returns to 00; len_err_o=0.
- s0 and s1 assert awvalid on the same cycle, FIXED_PRIO=0, after reset:
  - port 0 is served first, then port 1;
  - repeated simultaneous requests alternate 0,1,0,1.
- Same as above with FIXED_PRIO=1, both requesting continuously -> port 1 never granted while s0_awvalid stays high.
- s1 asserts wvalid with data 0x55 three cycles before s1_awvalid:
  - s1_wready stays 0 until the AW handshake;
  - no m_wvalid appears before m_awready has been seen.
- Port 0 awlen=3 but wlast on beat 2 -> len_err_o=1 after that beat and stays 1; the arbiter proceeds to RESP and then IDLE.
- arst_n pulsed low mid-DATA (beat 2 of 8):
  - all valid/ready drop asynchronously; grant_o=00, busy_o=0;
  - a new s1 request after release is granted normally.

Source files
------------

// File: rtl/tart_axi_pkg.sv
// Shared AXI4 encodings and arbiter state type for the TART DDR3 write/read arbiters.
package tart_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way one-hot grant select: a lone request wins outright; a tie goes to port 0
// under fixed priority, otherwise to the port that was not granted last.
module rr_arbiter2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ((FIXED_PRIO != 0) || last_grant_i) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ddr3_write_arbiter.sv
// Burst-locked two-port AXI4 write arbiter sharing the single DDR3 controller write port.
// Port 0 is raw-data acquisition, port 1 the USB bulk-out bridge; one transaction in flight.
module ddr3_write_arbiter
  import tart_axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int AXI_WIDTH  = 32,
  parameter int AXI_ADDRS  = 27,
  parameter int AXI_KEEPS  = AXI_WIDTH / 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic                 clock,
  input  logic                 arst_n,

  input  logic                 s0_awvalid,
  output logic                 s0_awready,
  input  logic [AXI_ADDRS-1:0] s0_awaddr,
  input  logic [ID_WIDTH-1:0]  s0_awid,
  input  logic [7:0]           s0_awlen,
  input  logic [1:0]           s0_awburst,
  input  logic                 s0_wvalid,
  output logic                 s0_wready,
  input  logic                 s0_wlast,
  input  logic [AXI_KEEPS-1:0] s0_wstrb,
  input  logic [AXI_WIDTH-1:0] s0_wdata,
  output logic                 s0_bvalid,
  input  logic                 s0_bready,
  output logic [1:0]           s0_bresp,
  output logic [ID_WIDTH-1:0]  s0_bid,

  input  logic                 s1_awvalid,
  output logic                 s1_awready,
  input  logic [AXI_ADDRS-1:0] s1_awaddr,
  input  logic [ID_WIDTH-1:0]  s1_awid,
  input  logic [7:0]           s1_awlen,
  input  logic [1:0]           s1_awburst,
  input  logic                 s1_wvalid,
  output logic                 s1_wready,
  input  logic                 s1_wlast,
  input  logic [AXI_KEEPS-1:0] s1_wstrb,
  input  logic [AXI_WIDTH-1:0] s1_wdata,
  output logic                 s1_bvalid,
  input  logic                 s1_bready,
  output logic [1:0]           s1_bresp,
  output logic [ID_WIDTH-1:0]  s1_bid,

  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [AXI_ADDRS-1:0] m_awaddr,
  output logic [ID_WIDTH-1:0]  m_awid,
  output logic [7:0]           m_awlen,
  output logic [1:0]           m_awburst,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  output logic                 m_wlast,
  output logic [AXI_KEEPS-1:0] m_wstrb,
  output logic [AXI_WIDTH-1:0] m_wdata,
  input  logic                 m_bvalid,
  output logic                 m_bready,
  input  logic [1:0]           m_bresp,
  input  logic [ID_WIDTH-1:0]  m_bid,

  output logic [1:0]           grant_o,
  output logic                 busy_o,
  output logic                 len_err_o
);

  arb_state_e           state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;
  logic                 len_err_q, len_err_d;
  logic [AXI_ADDRS-1:0] awaddr_q, awaddr_d;
  logic [ID_WIDTH-1:0]  awid_q, awid_d;
  logic [7:0]           awlen_q, awlen_d;
  logic [1:0]           awburst_q, awburst_d;

  logic [1:0]           arb_gnt;
  logic                 sel;
  logic                 g_wvalid, g_wlast, g_bready;
  logic [AXI_KEEPS-1:0] g_wstrb;
  logic [AXI_WIDTH-1:0] g_wdata;
  logic                 aw_hs, w_hs, b_hs;
  logic [1:0]           awready_v, wready_v, bvalid_v;

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_rr_arbiter2 (
    .req_i        ({s1_awvalid, s0_awvalid}),
    .last_grant_i (last_grant_q),
    .gnt_o        (arb_gnt)
  );

  // Only one grant bit is ever set, so bit 1 alone selects the active port.
  assign sel      = grant_q[1];
  assign g_wvalid = sel ? s1_wvalid : s0_wvalid;
  assign g_wlast  = sel ? s1_wlast  : s0_wlast;
  assign g_wstrb  = sel ? s1_wstrb  : s0_wstrb;
  assign g_wdata  = sel ? s1_wdata  : s0_wdata;
  assign g_bready = sel ? s1_bready : s0_bready;

  assign aw_hs = (state_q == ADDR) && m_awready;
  assign w_hs  = (state_q == DATA) && g_wvalid && m_wready;
  assign b_hs  = (state_q == RESP) && m_bvalid && g_bready;

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= 8'd0;
      len_err_q    <= 1'b0;
      awaddr_q     <= '0;
      awid_q       <= '0;
      awlen_q      <= 8'd0;
      awburst_q    <= BURST_FIXED;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      len_err_q    <= len_err_d;
      awaddr_q     <= awaddr_d;
      awid_q       <= awid_d;
      awlen_q      <= awlen_d;
      awburst_q    <= awburst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    len_err_d    = len_err_q;
    awaddr_d     = awaddr_q;
    awid_d       = awid_q;
    awlen_d      = awlen_q;
    awburst_d    = awburst_q;
    unique case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          grant_d   = arb_gnt;
          state_d   = ADDR;
          awaddr_d  = arb_gnt[1] ? s1_awaddr  : s0_awaddr;
          awid_d    = arb_gnt[1] ? s1_awid    : s0_awid;
          awlen_d   = arb_gnt[1] ? s1_awlen   : s0_awlen;
          awburst_d = arb_gnt[1] ? s1_awburst : s0_awburst;
        end
      end
      ADDR: begin
        if (aw_hs) begin
          beat_cnt_d = awlen_q;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q - 8'd1;
          // wlast must coincide with the counter reaching zero; wlast still ends the burst.
          if (g_wlast != (beat_cnt_q == 8'd0)) begin
            len_err_d = 1'b1;
          end
          if (g_wlast) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          last_grant_d = grant_q[1];
          grant_d      = 2'b00;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign awready_v[gi] = (state_q == ADDR) && grant_q[gi] && m_awready;
    assign wready_v[gi]  = (state_q == DATA) && grant_q[gi] && m_wready;
    assign bvalid_v[gi]  = (state_q == RESP) && grant_q[gi] && m_bvalid;
  end

  assign s0_awready = awready_v[0];
  assign s1_awready = awready_v[1];
  assign s0_wready  = wready_v[0];
  assign s1_wready  = wready_v[1];
  assign s0_bvalid  = bvalid_v[0];
  assign s1_bvalid  = bvalid_v[1];
  assign s0_bresp   = grant_q[0] ? m_bresp : RESP_OKAY;
  assign s1_bresp   = grant_q[1] ? m_bresp : RESP_OKAY;
  assign s0_bid     = grant_q[0] ? m_bid : '0;
  assign s1_bid     = grant_q[1] ? m_bid : '0;

  assign m_awvalid = (state_q == ADDR);
  assign m_awaddr  = awaddr_q;
  assign m_awid    = awid_q;
  assign m_awlen   = awlen_q;
  assign m_awburst = awburst_q;

  // W is gated by DATA so no beat can leak ahead of the AW handshake.
  assign m_wvalid = (state_q == DATA) && g_wvalid;
  assign m_wlast  = (state_q == DATA) && g_wlast;
  assign m_wstrb  = (state_q == DATA) ? g_wstrb : '0;
  assign m_wdata  = (state_q == DATA) ? g_wdata : '0;
  assign m_bready = (state_q == RESP) && g_bready;

  assign grant_o   = grant_q;
  assign busy_o    = (state_q != IDLE);
  assign len_err_o = len_err_q;

endmodule

// File: tb/tb_ddr3_write_arbiter.sv
// Scoreboard bench for ddr3_write_arbiter: directed bursts push expectations, a negedge
// monitor pops and compares on every controller AW/W and requester B handshake.
module tb_ddr3_write_arbiter;
  import tart_axi_pkg::*;

  localparam int IDW = 4;
  localparam int DW  = 32;
  localparam int AW  = 27;
  localparam int KW  = DW / 8;

  logic clock  = 1'b0;
  logic arst_n = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]     s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [AW-1:0]  s_awaddr  [2];
  logic [IDW-1:0] s_awid    [2];
  logic [7:0]     s_awlen   [2];
  logic [1:0]     s_awburst [2];
  logic [KW-1:0]  s_wstrb   [2];
  logic [DW-1:0]  s_wdata   [2];
  logic [1:0]     s_bresp   [2];
  logic [IDW-1:0] s_bid     [2];

  logic           m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [AW-1:0]  m_awaddr;
  logic [IDW-1:0] m_awid, m_bid;
  logic [7:0]     m_awlen;
  logic [1:0]     m_awburst, m_bresp;
  logic [KW-1:0]  m_wstrb;
  logic [DW-1:0]  m_wdata;
  logic [1:0]     grant_o;
  logic           busy_o, len_err_o;

  ddr3_write_arbiter #(.ID_WIDTH(IDW), .AXI_WIDTH(DW), .AXI_ADDRS(AW), .FIXED_PRIO(0)) dut (
    .clock(clock), .arst_n(arst_n),
    .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]), .s0_awaddr(s_awaddr[0]),
    .s0_awid(s_awid[0]), .s0_awlen(s_awlen[0]), .s0_awburst(s_awburst[0]),
    .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]), .s0_wlast(s_wlast[0]),
    .s0_wstrb(s_wstrb[0]), .s0_wdata(s_wdata[0]), .s0_bvalid(s_bvalid[0]),
    .s0_bready(s_bready[0]), .s0_bresp(s_bresp[0]), .s0_bid(s_bid[0]),
    .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]), .s1_awaddr(s_awaddr[1]),
    .s1_awid(s_awid[1]), .s1_awlen(s_awlen[1]), .s1_awburst(s_awburst[1]),
    .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]), .s1_wlast(s_wlast[1]),
    .s1_wstrb(s_wstrb[1]), .s1_wdata(s_wdata[1]), .s1_bvalid(s_bvalid[1]),
    .s1_bready(s_bready[1]), .s1_bresp(s_bresp[1]), .s1_bid(s_bid[1]),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awburst(m_awburst), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wlast(m_wlast), .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .grant_o(grant_o), .busy_o(busy_o), .len_err_o(len_err_o)
  );

  // Fixed-priority instance: both ports request single-beat bursts continuously.
  logic           fp_en = 1'b0;
  logic           fp_awready0, fp_awready1, fp_wready0, fp_wready1, fp_bvalid0, fp_bvalid1;
  logic [1:0]     fp_bresp0, fp_bresp1, fp_awburst, fp_grant;
  logic [IDW-1:0] fp_bid0, fp_bid1, fp_awid;
  logic           fp_awvalid, fp_wvalid, fp_wlast, fp_bready, fp_busy, fp_len_err;
  logic [AW-1:0]  fp_awaddr;
  logic [7:0]     fp_awlen;
  logic [KW-1:0]  fp_wstrb;
  logic [DW-1:0]  fp_wdata;

  ddr3_write_arbiter #(.ID_WIDTH(IDW), .AXI_WIDTH(DW), .AXI_ADDRS(AW), .FIXED_PRIO(1)) dut_fp (
    .clock(clock), .arst_n(arst_n),
    .s0_awvalid(fp_en), .s0_awready(fp_awready0), .s0_awaddr(27'h10), .s0_awid(4'h1),
    .s0_awlen(8'd0), .s0_awburst(2'b01), .s0_wvalid(1'b1), .s0_wready(fp_wready0),
    .s0_wlast(1'b1), .s0_wstrb(4'hF), .s0_wdata(32'h1), .s0_bvalid(fp_bvalid0),
    .s0_bready(1'b1), .s0_bresp(fp_bresp0), .s0_bid(fp_bid0),
    .s1_awvalid(fp_en), .s1_awready(fp_awready1), .s1_awaddr(27'h20), .s1_awid(4'h2),
    .s1_awlen(8'd0), .s1_awburst(2'b01), .s1_wvalid(1'b1), .s1_wready(fp_wready1),
    .s1_wlast(1'b1), .s1_wstrb(4'hF), .s1_wdata(32'h2), .s1_bvalid(fp_bvalid1),
    .s1_bready(1'b1), .s1_bresp(fp_bresp1), .s1_bid(fp_bid1),
    .m_awvalid(fp_awvalid), .m_awready(1'b1), .m_awaddr(fp_awaddr), .m_awid(fp_awid),
    .m_awlen(fp_awlen), .m_awburst(fp_awburst), .m_wvalid(fp_wvalid), .m_wready(1'b1),
    .m_wlast(fp_wlast), .m_wstrb(fp_wstrb), .m_wdata(fp_wdata), .m_bvalid(1'b1),
    .m_bready(fp_bready), .m_bresp(2'b00), .m_bid(4'h0),
    .grant_o(fp_grant), .busy_o(fp_busy), .len_err_o(fp_len_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit abort = 1'b0;

  typedef struct { int port; logic [AW-1:0] addr; logic [IDW-1:0] id; logic [7:0] len; } aw_t;
  typedef struct { logic [DW-1:0] data; logic last; } w_t;
  typedef struct { int port; logic [IDW-1:0] id; logic [1:0] resp; } b_t;
  aw_t awq[$];
  w_t  wq[$];
  b_t  bq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur within the cycle budget", name);
  endtask

  task automatic expect_burst(input int p, input logic [AW-1:0] addr, input logic [IDW-1:0] id,
                              input logic [7:0] len, input logic [DW-1:0] base, input int nbeats);
    aw_t a;
    w_t  w;
    b_t  b;
    a.port = p; a.addr = addr; a.id = id; a.len = len;
    awq.push_back(a);
    for (int i = 0; i < nbeats; i++) begin
      w.data = base + DW'(i);
      w.last = (i == nbeats - 1);
      wq.push_back(w);
    end
    b.port = p; b.id = id; b.resp = RESP_OKAY;
    bq.push_back(b);
  endtask

  task automatic do_burst(input int p, input logic [AW-1:0] addr, input logic [IDW-1:0] id,
                          input logic [7:0] len, input logic [DW-1:0] base, input int nbeats);
    int t;
    s_awaddr[p] = addr; s_awid[p] = id; s_awlen[p] = len; s_awburst[p] = BURST_INCR;
    s_awvalid[p] = 1'b1;
    t = 0;
    forever begin
      @(negedge clock);
      if (abort) return;
      if (s_awready[p]) break;
      check($sformatf("p%0d_wready_before_aw", p), s_wready[p], 1'b0);
      if (++t > 200) begin fail_now("aw_handshake"); return; end
    end
    @(posedge clock); #1;
    s_awvalid[p] = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      s_wvalid[p] = 1'b1; s_wdata[p] = base + DW'(i); s_wstrb[p] = '1;
      s_wlast[p] = (i == nbeats - 1);
      t = 0;
      forever begin
        @(negedge clock);
        if (abort) return;
        if (s_wready[p]) break;
        if (++t > 200) begin fail_now("w_handshake"); return; end
      end
      @(posedge clock); #1;
    end
    s_wvalid[p] = 1'b0; s_wlast[p] = 1'b0; s_bready[p] = 1'b1;
    t = 0;
    forever begin
      @(negedge clock);
      if (abort) return;
      if (s_bvalid[p]) break;
      if (++t > 200) begin fail_now("b_handshake"); s_bready[p] = 1'b0; return; end
    end
    @(posedge clock); #1;
    s_bready[p] = 1'b0;
  endtask

  // Controller model: accepts AW/W at once, answers OKAY with the captured ID after wlast.
  logic [IDW-1:0] cap_id = '0;
  initial begin
    bit pend, bdone;
    m_bvalid = 1'b0; m_bresp = 2'b11; m_bid = '0;
    forever begin
      @(negedge clock);
      pend  = arst_n && m_wvalid && m_wready && m_wlast;
      bdone = arst_n && m_bvalid && m_bready;
      if (arst_n && m_awvalid && m_awready) cap_id = m_awid;
      @(posedge clock); #1;
      if (!arst_n) begin
        m_bvalid = 1'b0;
      end else begin
        if (bdone) m_bvalid = 1'b0;
        if (pend) begin m_bvalid = 1'b1; m_bid = cap_id; m_bresp = RESP_OKAY; end
      end
    end
  end

  int w_hs_cnt = 0;
  bit aw_seen  = 1'b0;
  always @(negedge clock) begin
    aw_t a;
    w_t  w;
    b_t  b;
    if (!arst_n) begin
      aw_seen = 1'b0;
    end else begin
      if (m_awvalid && m_awready) begin
        if (awq.size() == 0) fail_now("aw_unexpected");
        else begin
          a = awq.pop_front();
          check("aw_grant", grant_o, (a.port == 0) ? 2'b01 : 2'b10);
          check("aw_addr", m_awaddr, a.addr);
          check("aw_id", m_awid, a.id);
          check("aw_len", m_awlen, a.len);
          check("aw_burst", m_awburst, BURST_INCR);
        end
        aw_seen = 1'b1;
      end
      if (m_wvalid) check("w_after_aw", aw_seen, 1'b1);
      if (m_wvalid && m_wready) begin
        w_hs_cnt++;
        if (wq.size() == 0) fail_now("w_unexpected");
        else begin
          w = wq.pop_front();
          check("w_data", m_wdata, w.data);
          check("w_last", m_wlast, w.last);
          check("w_strb", m_wstrb, 4'hF);
        end
        if (m_wlast) aw_seen = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (s_bvalid[p] && s_bready[p]) begin
          if (bq.size() == 0) fail_now("b_unexpected");
          else begin
            b = bq.pop_front();
            check("b_port", p, b.port);
            check("b_id", s_bid[p], b.id);
            check("b_resp", s_bresp[p], b.resp);
          end
        end
      end
    end
  end

  task automatic do_reset();
    arst_n = 1'b0;
    @(posedge clock); #1;
    arst_n = 1'b1;
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 2; p++) begin
      s_awvalid[p] = 1'b0; s_wvalid[p] = 1'b0; s_wlast[p] = 1'b0; s_bready[p] = 1'b0;
      s_awaddr[p] = '0; s_awid[p] = '0; s_awlen[p] = '0; s_awburst[p] = '0;
      s_wstrb[p] = '0; s_wdata[p] = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, g1, base_cnt, t;
    clear_inputs();
    m_awready = 1'b1;
    m_wready  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_grant", grant_o, 2'b00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_len_err", len_err_o, 1'b0);
    check("rst_m_awvalid", m_awvalid, 1'b0);
    check("rst_m_awaddr", m_awaddr, 27'h0);
    check("rst_m_wvalid", m_wvalid, 1'b0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_m_bready", m_bready, 1'b0);
    arst_n = 1'b1;
    @(posedge clock); #1;

    // Single requester, four beats.
    expect_burst(0, 27'h0001000, 4'h3, 8'd3, 32'hA0, 4);
    fork
      do_burst(0, 27'h0001000, 4'h3, 8'd3, 32'hA0, 4);
      begin
        @(negedge clock);
        check("lat_awvalid_c0", m_awvalid, 1'b0);
        check("lat_grant_c0", grant_o, 2'b00);
        @(negedge clock);
        check("lat_awvalid_c1", m_awvalid, 1'b1);
        check("lat_grant_c1", grant_o, 2'b01);
        check("lat_busy_c1", busy_o, 1'b1);
      end
    join
    @(negedge clock);
    check("t1_grant_end", grant_o, 2'b00);
    check("t1_busy_end", busy_o, 1'b0);
    check("t1_len_err", len_err_o, 1'b0);
    @(posedge clock); #1;

    // Round-robin from reset: 0,1,0,1.
    do_reset();
    expect_burst(0, 27'h100, 4'h1, 8'd1, 32'h10, 2);
    expect_burst(1, 27'h200, 4'h2, 8'd1, 32'h20, 2);
    expect_burst(0, 27'h300, 4'h5, 8'd0, 32'h30, 1);
    expect_burst(1, 27'h400, 4'h6, 8'd0, 32'h40, 1);
    fork
      do_burst(0, 27'h100, 4'h1, 8'd1, 32'h10, 2);
      do_burst(1, 27'h200, 4'h2, 8'd1, 32'h20, 2);
    join
    fork
      do_burst(0, 27'h300, 4'h5, 8'd0, 32'h30, 1);
      do_burst(1, 27'h400, 4'h6, 8'd0, 32'h40, 1);
    join

    // Fixed priority: continuous ties always go to port 0 (3 of every 4 cycles granted).
    g0 = 0; g1 = 0;
    fp_en = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (fp_grant[0]) g0++;
      if (fp_grant[1]) g1++;
    end
    fp_en = 1'b0;
    check("fp_p1_grant_cycles", g1, 0);
    check("fp_p0_grant_cycles", g0, 30);
    check("fp_len_err", fp_len_err, 1'b0);
    @(posedge clock); #1;

    // W presented before AW must stall.
    s_wvalid[1] = 1'b1; s_wdata[1] = 32'h55; s_wstrb[1] = '1; s_wlast[1] = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("stall_s1_wready", s_wready[1], 1'b0);
      check("stall_m_wvalid", m_wvalid, 1'b0);
    end
    @(posedge clock); #1;
    expect_burst(1, 27'h2000, 4'h9, 8'd0, 32'h55, 1);
    do_burst(1, 27'h2000, 4'h9, 8'd0, 32'h55, 1);

    // Early wlast: awlen=3 but wlast on beat 2.
    @(negedge clock);
    check("lerr_before", len_err_o, 1'b0);
    @(posedge clock); #1;
    expect_burst(0, 27'h3000, 4'hA, 8'd3, 32'hC0, 2);
    do_burst(0, 27'h3000, 4'hA, 8'd3, 32'hC0, 2);
    @(negedge clock);
    check("lerr_set", len_err_o, 1'b1);
    check("lerr_grant_end", grant_o, 2'b00);
    check("lerr_busy_end", busy_o, 1'b0);
    @(posedge clock); #1;
    expect_burst(0, 27'h4000, 4'hB, 8'd0, 32'hD0, 1);
    do_burst(0, 27'h4000, 4'hB, 8'd0, 32'hD0, 1);
    @(negedge clock);
    check("lerr_sticky", len_err_o, 1'b1);
    @(posedge clock); #1;

    // Asynchronous reset after beat 2 of an 8-beat burst.
    expect_burst(0, 27'h5000, 4'hC, 8'd7, 32'hE0, 8);
    base_cnt = w_hs_cnt;
    fork
      do_burst(0, 27'h5000, 4'hC, 8'd7, 32'hE0, 8);
      begin
        t = 0;
        while (w_hs_cnt < base_cnt + 2 && t < 200) begin
          @(negedge clock); #1;
          t++;
        end
        if (t >= 200) fail_now("mid_burst_beats");
        @(posedge clock); #3;
        abort  = 1'b1;
        arst_n = 1'b0;
        #1;
        check("arst_m_wvalid", m_wvalid, 1'b0);
        check("arst_s0_wready", s_wready[0], 1'b0);
        check("arst_m_awvalid", m_awvalid, 1'b0);
        check("arst_grant", grant_o, 2'b00);
        check("arst_busy", busy_o, 1'b0);
        check("arst_len_err", len_err_o, 1'b0);
      end
    join
    awq.delete(); wq.delete(); bq.delete();
    clear_inputs();
    @(posedge clock); #1;
    arst_n = 1'b1;
    abort  = 1'b0;
    @(posedge clock); #1;
    expect_burst(1, 27'h6000, 4'hD, 8'd1, 32'hF0, 2);
    do_burst(1, 27'h6000, 4'hD, 8'd1, 32'hF0, 2);
    @(negedge clock);
    check("post_rst_grant", grant_o, 2'b00);
    check("post_rst_len_err", len_err_o, 1'b0);

    repeat (3) @(negedge clock);
    check("awq_drained", awq.size(), 0);
    check("wq_drained", wq.size(), 0);
    check("bq_drained", bq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
